// File: rtl/spi_master_xfer.sv
// spi_master_xfer: parametrised full-duplex SPI master with
// valid/ready command and result handshakes, all four SPI modes.
`timescale 1ns/1ps
module spi_master_xfer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 2,
  parameter int CLK_DIV    = 2,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  tx_data_i,
  input  logic [$clog2(NUM_CS > 1 ? NUM_CS : 2)-1:0] tx_cs_i,
  input  logic                   tx_rd_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [DATA_WIDTH-1:0]  rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   busy_o,
  output logic                   sck_o,
  output logic [NUM_CS-1:0]      cs_n_o,
  output logic                   mosi_o,
  input  logic                   miso_i
);

  localparam int CSW = $clog2(NUM_CS > 1 ? NUM_CS : 2);
  localparam int EW  = $clog2(2 * DATA_WIDTH) + 1;
  localparam int DVW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [DVW-1:0] DIV_END   = DVW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t state, state_d;
  logic [DVW-1:0] div_cnt, div_d;
  logic [EW-1:0] edge_cnt, edge_d;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_q_d;
  logic [NUM_CS-1:0] cs_n, cs_n_d;
  logic rd, rd_d;
  logic sck, sck_d;
  logic mosi, mosi_d;
  logic rx_v, rx_v_d;
  logic rdy, rdy_d;
  logic accept, half_end, lead, sample, shift;

  function automatic logic [DATA_WIDTH-1:0] adv(
    input logic [DATA_WIDTH-1:0] v
  );
    return LSB_FIRST ? v >> 1 : v << 1;
  endfunction

  function automatic logic head(
    input logic [DATA_WIDTH-1:0] v
  );
    return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
  endfunction

  assign accept   = tx_valid_i && rdy;
  assign half_end = (div_cnt == DIV_END);
  // even edge index = leading edge (SCK leaves its idle level)
  assign lead     = !edge_cnt[0];
  assign sample   = half_end && (lead != CPHA);
  assign shift    = half_end && (lead == CPHA) &&
                    (CPHA || edge_cnt != LAST_EDGE);

  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    edge_d  = edge_cnt;
    tx_sh_d = tx_sh;
    rx_sh_d = rx_sh;
    rx_q_d  = rx_q;
    cs_n_d  = cs_n;
    rd_d    = rd;
    sck_d   = sck;
    mosi_d  = mosi;
    rx_v_d  = rx_v;
    if (rx_v && rx_ready_i) rx_v_d = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        state_d = SETUP;
        div_d   = '0;
        edge_d  = '0;
        rd_d    = tx_rd_i;
        rx_sh_d = '0;
        for (int i = 0; i < NUM_CS; i++)
          cs_n_d[i] = (tx_cs_i != CSW'(i));
        // CPHA=0 presents bit one before the first edge
        if (CPHA) begin
          tx_sh_d = tx_data_i;
        end else begin
          tx_sh_d = adv(tx_data_i);
          mosi_d  = head(tx_data_i);
        end
      end
      SETUP: begin
        div_d = div_cnt + 1'b1;
        if (half_end) begin
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_cnt + 1'b1;
        if (half_end) begin
          div_d  = '0;
          sck_d  = ~sck;
          edge_d = edge_cnt + 1'b1;
          if (edge_cnt == LAST_EDGE) state_d = HOLD;
        end
        if (sample)
          rx_sh_d = LSB_FIRST ?
            {miso_i, rx_sh[DATA_WIDTH-1:1]} :
            {rx_sh[DATA_WIDTH-2:0], miso_i};
        if (shift) begin
          mosi_d  = head(tx_sh);
          tx_sh_d = adv(tx_sh);
        end
      end
      HOLD: begin
        div_d = div_cnt + 1'b1;
        if (half_end) begin
          div_d   = '0;
          state_d = IDLE;
          cs_n_d  = '1;
          mosi_d  = 1'b0;
          if (rd) begin
            rx_q_d = rx_sh;
            rx_v_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state == IDLE) && !rx_v && !accept;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_q     <= '0;
      cs_n     <= '1;
      rd       <= 1'b0;
      sck      <= CPOL;
      mosi     <= 1'b0;
      rx_v     <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_d;
      edge_cnt <= edge_d;
      tx_sh    <= tx_sh_d;
      rx_sh    <= rx_sh_d;
      rx_q     <= rx_q_d;
      cs_n     <= cs_n_d;
      rd       <= rd_d;
      sck      <= sck_d;
      mosi     <= mosi_d;
      rx_v     <= rx_v_d;
      rdy      <= rdy_d;
    end
  end

  assign tx_ready_o = rdy;
  assign rx_data_o  = rx_q;
  assign rx_valid_o = rx_v;
  assign busy_o     = (state != IDLE);
  assign sck_o      = sck;
  assign cs_n_o     = cs_n;
  assign mosi_o     = mosi;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: four instances (one per SPI mode) share
// the command stream; each has its own behavioural SPI slave.
`timescale 1ns/1ps
module tb_spi_master_xfer;

  typedef struct {
    logic [7:0] d;
    logic [7:0] s;
    logic [1:0] cs;
    logic       rd;
    logic [7:0] exp_rx;
    logic [2:0] exp_seen;
    int         exp_cl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic [1:0] tx_cs = '0;
  logic tx_rd = 1'b0;
  logic tx_valid = 1'b0;
  logic rx_ready = 1'b0;
  logic [7:0] slv_s = '0;

  logic tx_ready [4];
  logic [7:0] rx_data [4];
  logic rx_valid [4];
  logic busy [4];
  logic sck [4];
  logic [2:0] cs_n [4];
  logic mosi [4];

  logic [7:0] cap_w [4];
  logic [2:0] seen_w [4];
  int ed_w [4];
  int cl_w [4];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rx = '0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g
    localparam bit P = (m / 2) == 1;
    localparam bit H = (m % 2) == 1;
    localparam bit L = (m != 0);
    logic so = 1'b0;
    logic bq = 1'b0;
    logic sq = P;
    int ns = 0;
    int nc = 0;
    int ed = 0;
    int cl = 0;
    logic [2:0] bi;
    logic [7:0] cap = '0;
    logic [2:0] seen = '0;

    spi_master_xfer #(
      .DATA_WIDTH(8), .NUM_CS(3), .CLK_DIV(2),
      .CPOL(P), .CPHA(H), .LSB_FIRST(L)
    ) dut (
      .clk_i(clk), .rst_i(rst),
      .tx_data_i(tx_data), .tx_cs_i(tx_cs),
      .tx_rd_i(tx_rd), .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready[m]),
      .rx_data_o(rx_data[m]), .rx_valid_o(rx_valid[m]),
      .rx_ready_i(rx_ready), .busy_o(busy[m]),
      .sck_o(sck[m]), .cs_n_o(cs_n[m]),
      .mosi_o(mosi[m]), .miso_i(so)
    );

    // slave: sample on leading edge when CPHA=0, trailing when CPHA=1
    always @(negedge clk) begin
      if (busy[m] && !bq) begin
        ns = 0; nc = 0; ed = 0; cl = 0;
        cap = '0; seen = '0;
        if (!H) begin
          so = L ? slv_s[0] : slv_s[7];
          ns = 1;
        end
      end
      if (busy[m] && sck[m] != sq) begin
        ed++;
        if ((sck[m] != P) == !H) begin
          bi = 3'(nc);
          if (nc < 8) cap[L ? bi : 3'd7 - bi] = mosi[m];
          nc++;
        end else begin
          bi = 3'(ns);
          if (ns < 8) so = L ? slv_s[bi] : slv_s[3'd7 - bi];
          ns++;
        end
      end
      if (cs_n[m] != 3'b111) begin
        cl++;
        seen = seen | ~cs_n[m];
      end
      bq = busy[m];
      sq = sck[m];
    end

    assign cap_w[m]  = cap;
    assign seen_w[m] = seen;
    assign ed_w[m]   = ed;
    assign cl_w[m]   = cl;
  end

  function automatic logic cpol(input int m);
    return m >= 2;
  endfunction

  function automatic vec_t model(
    input logic [7:0] d, input logic [7:0] s,
    input logic [1:0] cs, input logic rd,
    input logic [7:0] prev
  );
    vec_t v;
    v.d = d; v.s = s; v.cs = cs; v.rd = rd;
    v.exp_rx   = rd ? s : prev;
    v.exp_seen = (cs < 2'd3) ? 3'(1 << cs) : 3'b000;
    v.exp_cl   = (cs < 2'd3) ? 2 * (2 * 8 + 2) : 0;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    int n = 0;
    for (int m = 0; m < 4; m++)
      chk($sformatf("sck_idle_pre[%0d]", m), sck[m], cpol(m));
    slv_s = v.s;
    tx_data = v.d; tx_cs = v.cs; tx_rd = v.rd;
    tx_valid = 1'b1;
    while (!tx_ready[0] && n < 400) begin
      tick();
      n++;
    end
    chk("cmd_ready", tx_ready[0], 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input vec_t v);
    int n = 0;
    logic pv = 1'b0;
    do begin
      pv = rx_valid[0];
      tick();
      n++;
    end while (busy[0] && n < 400);
    chk("done", busy[0], 0);
    if (v.rd) chk("rxv_early", pv, 0);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rxv[%0d]", m), rx_valid[m], v.rd);
      chk($sformatf("rx[%0d]", m), rx_data[m], v.exp_rx);
      chk($sformatf("cs_hi[%0d]", m), cs_n[m], 3'b111);
      chk($sformatf("mosi0[%0d]", m), mosi[m], 0);
      chk($sformatf("sck_idle[%0d]", m), sck[m], cpol(m));
      chk($sformatf("edges[%0d]", m), ed_w[m], 16);
      chk($sformatf("mosi_bits[%0d]", m), cap_w[m], v.d);
      chk($sformatf("cs_len[%0d]", m), cl_w[m], v.exp_cl);
      chk($sformatf("cs_sel[%0d]", m), seen_w[m], v.exp_seen);
    end
    if (v.rd) begin
      last_rx = v.s;
    end else begin
      chk("rdy_lag", tx_ready[0], 0);
      tick();
      chk("rdy_back", tx_ready[0], 1);
    end
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    tick();
    for (int m = 0; m < 4; m++)
      chk($sformatf("rxv_clr[%0d]", m), rx_valid[m], 0);
  endtask

  task automatic run(input vec_t v);
    issue(v);
    wait_done(v);
    if (v.rd) consume();
  endtask

  initial begin
    vec_t tbl [6];
    vec_t v, v2;
    int n;
    logic ok, hold;

    tbl[0] = '{8'hA5, 8'hA5, 2'd0, 1'b1, 8'hA5, 3'b001, 36};
    tbl[1] = '{8'h3C, 8'hC3, 2'd0, 1'b1, 8'hC3, 3'b001, 36};
    tbl[2] = '{8'hFF, 8'h00, 2'd1, 1'b0, 8'hC3, 3'b010, 36};
    tbl[3] = '{8'h5A, 8'h96, 2'd3, 1'b1, 8'h96, 3'b000, 0};
    tbl[4] = '{8'h00, 8'hFF, 2'd2, 1'b1, 8'hFF, 3'b100, 36};
    tbl[5] = '{8'h81, 8'h7E, 2'd2, 1'b0, 8'hFF, 3'b100, 36};

    repeat (3) tick();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_sck[%0d]", m), sck[m], cpol(m));
      chk($sformatf("rst_cs[%0d]", m), cs_n[m], 3'b111);
      chk($sformatf("rst_mosi[%0d]", m), mosi[m], 0);
      chk($sformatf("rst_rxv[%0d]", m), rx_valid[m], 0);
      chk($sformatf("rst_rx[%0d]", m), rx_data[m], 0);
      chk($sformatf("rst_rdy[%0d]", m), tx_ready[m], 0);
      chk($sformatf("rst_busy[%0d]", m), busy[m], 0);
    end
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", tx_ready[0], 1);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // backpressure: second command waits for the first result
    v  = model(8'h11, 8'h22, 2'd0, 1'b1, last_rx);
    issue(v);
    wait_done(v);
    v2 = model(8'h33, 8'h44, 2'd1, 1'b1, last_rx);
    slv_s = v2.s;
    tx_data = v2.d; tx_cs = v2.cs; tx_rd = v2.rd;
    tx_valid = 1'b1;
    ok = 1'b1;
    hold = 1'b1;
    repeat (30) begin
      tick();
      if (tx_ready[0] || busy[0]) ok = 1'b0;
      for (int m = 0; m < 4; m++)
        if (rx_data[m] !== v.s || rx_valid[m] !== 1'b1)
          hold = 1'b0;
    end
    chk("bp_block", ok, 1);
    chk("bp_hold", hold, 1);
    consume();
    issue(v2);
    wait_done(v2);
    consume();

    for (int i = 0; i < 24; i++) begin
      v = model(8'($urandom), 8'($urandom),
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), last_rx);
      run(v);
    end

    // reset in the middle of a transfer
    v = model(8'h6B, 8'h9D, 2'd0, 1'b1, last_rx);
    issue(v);
    n = 0;
    do begin
      tick();
      n++;
    end while (ed_w[0] < 7 && n < 400);
    chk("edge7", ed_w[0], 7);
    rst = 1'b1;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("mid_cs[%0d]", m), cs_n[m], 3'b111);
      chk($sformatf("mid_sck[%0d]", m), sck[m], cpol(m));
      chk($sformatf("mid_busy[%0d]", m), busy[m], 0);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    last_rx = '0;
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("post_rxv[%0d]", m), rx_valid[m], 0);
      chk($sformatf("post_rx[%0d]", m), rx_data[m], last_rx);
    end
    chk("post_rdy", tx_ready[0], 1);
    run(model(8'hC6, 8'h39, 2'd0, 1'b1, last_rx));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
